// File: rtl/hazard3_clint_timer.sv
// Hazard3-style CLINT: APB-mapped MSIP / MTIME / MTIMECMP with a fixed single wait state.
// Define HAZARD3_CLINT_PRESCALE_EN to add an 8-bit tick prescaler register at 0x0300.
module hazard3_clint_timer #(
  parameter int N_HARTS     = 2,
  parameter int TICK_IS_NRZ = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        paddr,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic               dbg_halt,
  input  logic               tick,
  output logic [N_HARTS-1:0] soft_irq,
  output logic [N_HARTS-1:0] timer_irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_RESP, ST_DONE} apb_state_e;

  apb_state_e         r_state;
  apb_state_e         w_state_nxt;
  logic [63:0]        r_mtime;
  logic [63:0]        r_mtimecmp [N_HARTS];
  logic [N_HARTS-1:0] r_msip;
  logic [N_HARTS-1:0] r_timer_irq;
  logic [31:0]        r_prdata;
  logic               r_pslverr;
  logic [31:0]        w_rdata;
  logic               w_aligned;
  logic               w_msip_sel;
  logic               w_mtime_sel;
  logic               w_cmp_sel;
  logic               w_pre_sel;
  logic               w_err;
  logic               w_access;
  logic               w_wr;
  logic               w_tick_evt;
  logic               w_inc;
`ifdef HAZARD3_CLINT_PRESCALE_EN
  logic [7:0]         r_prescale;
  logic [7:0]         r_pre_cnt;
`endif

  // ---------------------------------------------------------------- decode
  assign w_aligned   = (paddr[1:0] == 2'b00);
  assign w_msip_sel  = w_aligned && (paddr[15:8] == 8'h00) && (int'(paddr[7:2]) < N_HARTS);
  assign w_mtime_sel = w_aligned && (paddr[15:3] == 13'h0020);
  assign w_cmp_sel   = w_aligned && (paddr[15:8] == 8'h02) && (int'(paddr[7:3]) < N_HARTS);
`ifdef HAZARD3_CLINT_PRESCALE_EN
  assign w_pre_sel   = (paddr == 16'h0300);
`else
  assign w_pre_sel   = 1'b0;
`endif
  assign w_err       = !(w_msip_sel || w_mtime_sel || w_cmp_sel || w_pre_sel);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_rdata = '0;
    if (w_mtime_sel) w_rdata = paddr[2] ? r_mtime[63:32] : r_mtime[31:0];
    for (int h = 0; h < N_HARTS; h++) begin
      if (w_msip_sel && (paddr[7:2] == 6'(h))) w_rdata = {31'd0, r_msip[h]};
      if (w_cmp_sel && (paddr[7:3] == 5'(h)))
        w_rdata = paddr[2] ? r_mtimecmp[h][63:32] : r_mtimecmp[h][31:0];
    end
`ifdef HAZARD3_CLINT_PRESCALE_EN
    if (w_pre_sel) w_rdata = {24'd0, r_prescale};
`endif
  end

  // ---------------------------------------------------------------- APB handshake
  // DONE holds off a new response until the master drops penable after completion.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (psel && penable) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_DONE;
      ST_DONE: if (!penable) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_access = (r_state == ST_IDLE) && psel && penable;
  assign w_wr     = (r_state == ST_RESP) && psel && penable && pwrite && !r_pslverr;

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_access) begin
        r_prdata  <= pwrite ? 32'd0 : w_rdata;
        r_pslverr <= w_err;
      end
    end
  end

  assign pready  = (r_state == ST_RESP);
  assign prdata  = r_prdata;
  assign pslverr = r_pslverr;

  // ---------------------------------------------------------------- tick event
  generate
    if (TICK_IS_NRZ != 0) begin : g_tick_nrz
      logic [2:0] r_tick_sync;  // [1:0] synchroniser, [2] edge-detect history
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tick_sync <= '0;
        else        r_tick_sync <= {r_tick_sync[1:0], tick};
      end
      assign w_tick_evt = r_tick_sync[2] ^ r_tick_sync[1];
    end else begin : g_tick_level
      assign w_tick_evt = tick;
    end
  endgenerate

`ifdef HAZARD3_CLINT_PRESCALE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale <= '0;
      r_pre_cnt  <= '0;
    end else if (w_wr && w_pre_sel) begin
      r_prescale <= pwdata[7:0];
      r_pre_cnt  <= '0;
    end else if (w_tick_evt && !dbg_halt) begin
      r_pre_cnt <= (r_pre_cnt == r_prescale) ? 8'd0 : r_pre_cnt + 8'd1;
    end
  end
  assign w_inc = w_tick_evt && !dbg_halt && (r_pre_cnt == r_prescale);
`else
  assign w_inc = w_tick_evt && !dbg_halt;
`endif

  // ---------------------------------------------------------------- timer / IRQ state
  // A bus write to either MTIME half cancels that cycle's increment, so no carry crosses halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime <= '0;
    end else if (w_wr && w_mtime_sel) begin
      if (paddr[2]) r_mtime[63:32] <= pwdata;
      else          r_mtime[31:0]  <= pwdata;
    end else if (w_inc) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // NOTE: the compare array is a handful of flops, not a RAM, so it takes the async reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msip      <= '0;
      r_timer_irq <= '0;
      for (int h = 0; h < N_HARTS; h++) r_mtimecmp[h] <= '1;
    end else begin
      for (int h = 0; h < N_HARTS; h++) begin
        if (w_wr && w_msip_sel && (paddr[7:2] == 6'(h))) r_msip[h] <= pwdata[0];
        if (w_wr && w_cmp_sel && (paddr[7:3] == 5'(h))) begin
          if (paddr[2]) r_mtimecmp[h][63:32] <= pwdata;
          else          r_mtimecmp[h][31:0]  <= pwdata;
        end
        r_timer_irq[h] <= (r_mtime >= r_mtimecmp[h]);
      end
    end
  end

  assign soft_irq  = r_msip;
  assign timer_irq = r_timer_irq;

endmodule

// File: tb/tb_hazard3_clint_timer.sv
// Scoreboard bench for hazard3_clint_timer: a level-tick 4-hart instance and an NRZ-tick 2-hart instance.
module tb_hazard3_clint_timer;

  localparam int NH_A = 4;
  localparam int NH_B = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [15:0]     paddr;
  logic            psel_a, psel_b, penable, pwrite;
  logic [31:0]     pwdata;
  logic [31:0]     prdata_a, prdata_b;
  logic            pready_a, pready_b, pslverr_a, pslverr_b;
  logic            dbg_halt, tick_a, tick_b;
  logic [NH_A-1:0] soft_irq_a, timer_irq_a;
  logic [NH_B-1:0] soft_irq_b, timer_irq_b;
  bit              tick_in_xfer;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  hazard3_clint_timer #(.N_HARTS(NH_A), .TICK_IS_NRZ(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel_a), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a),
    .pslverr(pslverr_a), .dbg_halt(dbg_halt), .tick(tick_a),
    .soft_irq(soft_irq_a), .timer_irq(timer_irq_a)
  );

  hazard3_clint_timer #(.N_HARTS(NH_B), .TICK_IS_NRZ(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel_b), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b),
    .pslverr(pslverr_b), .dbg_halt(dbg_halt), .tick(tick_b),
    .soft_irq(soft_irq_b), .timer_irq(timer_irq_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  // Called and returns on a falling edge; hold keeps penable high extra cycles after completion.
  task automatic apb(input bit use_b, input logic [15:0] addr, input bit wr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input bit exp_err, input int hold, input string tag);
    int   n;
    int   late;
    logic rdy;
    sb_push({tag, ".err"}, 64'(exp_err));
    if (!wr) sb_push({tag, ".rd"}, 64'(exp_rd));
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wdata;
    penable = 1'b0;
    if (use_b) psel_b = 1'b1; else psel_a = 1'b1;
    if (tick_in_xfer) tick_a = 1'b1;
    @(negedge clk);
    rdy = use_b ? pready_b : pready_a;
    check({tag, ".setup_rdy"}, 64'(rdy), 64'd0);
    penable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      rdy = use_b ? pready_b : pready_a;
    end while (!rdy && n < 8);
    check({tag, ".wait"}, 64'(n), 64'd1);
    sb_check(64'(use_b ? pslverr_b : pslverr_a));
    if (!wr) sb_check(64'(use_b ? prdata_b : prdata_a));
    late = 0;
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      if (tick_in_xfer) tick_a = 1'b0;
      if (use_b ? pready_b : pready_a) late++;
    end
    check({tag, ".drop"}, 64'(late), 64'd0);
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
  endtask

  task automatic tick_cycles(input int n);
    tick_a = 1'b1;
    repeat (n) @(negedge clk);
    tick_a = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; paddr = '0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    pwrite = 1'b0; pwdata = '0; dbg_halt = 1'b0; tick_a = 1'b0; tick_b = 1'b0;
    tick_in_xfer = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    sb_push("rst.soft_irq", 64'd0);  sb_check(64'(soft_irq_a));
    sb_push("rst.timer_irq", 64'd0); sb_check(64'(timer_irq_a));
    sb_push("rst.pready", 64'd0);    sb_check(64'(pready_a));
    sb_push("rst.pslverr", 64'd0);   sb_check(64'(pslverr_a));
    sb_push("rst.prdata", 64'd0);    sb_check(64'(prdata_a));
    apb(0, 16'h0200, 0, 0, 32'hFFFF_FFFF, 0, 0, "rst.cmp0_lo");
    apb(0, 16'h0204, 0, 0, 32'hFFFF_FFFF, 0, 0, "rst.cmp0_hi");
    apb(0, 16'h0100, 0, 0, 32'h0, 0, 0, "rst.mtime_lo");

    // MSIP and decode errors
    apb(0, 16'h000C, 1, 32'h1, 0, 0, 0, "msip3.set");
    sb_push("msip3.soft_irq", 64'h8); sb_check(64'(soft_irq_a));
    apb(0, 16'h000C, 0, 0, 32'h1, 0, 0, "msip3.read");
    apb(0, 16'h000C, 1, 32'h2, 0, 0, 0, "msip3.clr");
    sb_push("msip3.soft_irq0", 64'h0); sb_check(64'(soft_irq_a));
    apb(0, 16'h0010, 0, 0, 32'h0, 1, 0, "err.msip4_rd");
    apb(0, 16'h0010, 1, 32'h1, 0, 1, 0, "err.msip4_wr");
    sb_push("err.soft_irq", 64'h0); sb_check(64'(soft_irq_a));
    apb(0, 16'h0102, 0, 0, 32'h0, 1, 0, "err.unaligned");
    apb(0, 16'h0220, 0, 0, 32'h0, 1, 0, "err.cmp4");
    apb(0, 16'h0400, 0, 0, 32'h0, 1, 0, "err.unmapped");
    apb(0, 16'h0218, 0, 0, 32'hFFFF_FFFF, 0, 0, "cmp3_lo");

    // MTIMECMP compare and IRQ latency
    apb(0, 16'h020C, 1, 32'h0, 0, 0, 0, "cmp1_hi.wr");
    apb(0, 16'h0208, 1, 32'h10, 0, 0, 0, "cmp1_lo.wr");
    apb(0, 16'h0208, 0, 0, 32'h10, 0, 0, "cmp1_lo.rd");
    apb(0, 16'h020C, 0, 0, 32'h0, 0, 0, "cmp1_hi.rd");
    apb(0, 16'h0100, 1, 32'h0F, 0, 0, 0, "mtime_0f.wr");
    sb_push("tirq.before", 64'h0); sb_check(64'(timer_irq_a));
    tick_cycles(1);
    sb_push("tirq.same_clk", 64'h0); sb_check(64'(timer_irq_a));
    @(negedge clk);
    sb_push("tirq.one_clk", 64'h2); sb_check(64'(timer_irq_a));
    apb(0, 16'h0208, 1, 32'h20, 0, 0, 0, "cmp1_lo.wr20");
    @(negedge clk);
    sb_push("tirq.cleared", 64'h0); sb_check(64'(timer_irq_a));

    // Halted ticks are discarded
    dbg_halt = 1'b1;
    tick_cycles(5);
    dbg_halt = 1'b0;
    @(negedge clk);
    apb(0, 16'h0100, 0, 0, 32'h10, 0, 0, "halt.mtime_lo");

    // Low-word wrap carries into the high word
    apb(0, 16'h0104, 1, 32'h0, 0, 0, 0, "wrap.hi_wr");
    apb(0, 16'h0100, 1, 32'hFFFF_FFFE, 0, 0, 0, "wrap.lo_wr");
    tick_cycles(3);
    apb(0, 16'h0100, 0, 0, 32'h1, 0, 0, "wrap.lo");
    apb(0, 16'h0104, 0, 0, 32'h1, 0, 0, "wrap.hi");

    // Bus write beats a simultaneous tick and leaves the other half alone
    tick_in_xfer = 1'b1;
    apb(0, 16'h0100, 1, 32'hFFFF_FFFF, 0, 0, 0, "prio.lo_wr");
    tick_in_xfer = 1'b0;
    apb(0, 16'h0100, 0, 0, 32'hFFFF_FFFF, 0, 0, "prio.lo");
    apb(0, 16'h0104, 0, 0, 32'h1, 0, 0, "prio.hi");
    tick_cycles(1);
    apb(0, 16'h0100, 0, 0, 32'h0, 0, 0, "carry.lo");
    apb(0, 16'h0104, 0, 0, 32'h2, 0, 0, "carry.hi");

    // Full 64-bit wrap
    apb(0, 16'h0104, 1, 32'hFFFF_FFFF, 0, 0, 0, "wrap64.hi_wr");
    apb(0, 16'h0100, 1, 32'hFFFF_FFFF, 0, 0, 0, "wrap64.lo_wr");
    tick_cycles(1);
    apb(0, 16'h0100, 0, 0, 32'h0, 0, 0, "wrap64.lo");
    apb(0, 16'h0104, 0, 0, 32'h0, 0, 0, "wrap64.hi");

`ifdef HAZARD3_CLINT_PRESCALE_EN
    apb(0, 16'h0300, 1, 32'h3, 0, 0, 0, "pre.wr");
    apb(0, 16'h0300, 0, 0, 32'h3, 0, 0, "pre.rd");
    tick_cycles(12);
    apb(0, 16'h0100, 0, 0, 32'h3, 0, 0, "pre.mtime_lo");
`else
    apb(0, 16'h0300, 0, 0, 32'h0, 1, 0, "pre.absent_rd");
    apb(0, 16'h0300, 1, 32'h3, 0, 1, 0, "pre.absent_wr");
`endif

    // NRZ tick: four slow toggles, second one lost to dbg_halt
    for (int i = 0; i < 4; i++) begin
      if (i == 1) dbg_halt = 1'b1;
      tick_b = ~tick_b;
      repeat (6) @(negedge clk);
      dbg_halt = 1'b0;
    end
    apb(1, 16'h0100, 0, 0, 32'h3, 0, 0, "nrz.mtime_lo");
    apb(1, 16'h0104, 0, 0, 32'h0, 0, 0, "nrz.mtime_hi");

    // pready stays low while penable is held after completion
    apb(0, 16'h0208, 0, 0, 32'h20, 0, 3, "hold.cmp1_lo");

    // Reset in the response cycle aborts the write; next transfer is normal
    paddr = 16'h0000; pwrite = 1'b1; pwdata = 32'h1; psel_a = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    psel_a = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sb_push("abort.soft_irq", 64'h0); sb_check(64'(soft_irq_a));
    sb_push("abort.pready", 64'h0);   sb_check(64'(pready_a));
    apb(0, 16'h0000, 0, 0, 32'h0, 0, 0, "abort.msip0");
    apb(0, 16'h0204, 0, 0, 32'hFFFF_FFFF, 0, 0, "abort.cmp0_hi");
    apb(0, 16'h0104, 0, 0, 32'h0, 0, 0, "abort.mtime_hi");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
